// File: rtl/sdram_arbit_if.sv
// rtl/sdram_arbit_if.sv - sequencer-side and pin-side signal bundle for sdram_arbit
interface sdram_arbit_if;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;

    logic        ref_req;
    logic        ref_end;
    logic [3:0]  ref_cmd;
    logic [11:0] ref_addr;
    logic        ref_en;

    logic        wr_req;
    logic        wr_end;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  wr_bank;
    logic [15:0] wr_data;
    logic        wr_en;

    logic        rd_req;
    logic        rd_end;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  rd_bank;
    logic        rd_en;

    logic        sdram_cke;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_ba;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;
    logic        grant_err;

    // Sequencers and pin consumer side
    modport master (
        output init_end, init_cmd, init_addr,
        output ref_req, ref_end, ref_cmd, ref_addr,
        output wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
        output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
        input  ref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cmd, sdram_addr, sdram_ba,
        input  sdram_dq_out, sdram_dq_oe, grant_err
    );

    // Arbiter side
    modport slave (
        input  init_end, init_cmd, init_addr,
        input  ref_req, ref_end, ref_cmd, ref_addr,
        input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
        input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
        output ref_en, wr_en, rd_en,
        output sdram_cke, sdram_cmd, sdram_addr, sdram_ba,
        output sdram_dq_out, sdram_dq_oe, grant_err
    );
endinterface

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command arbiter: init, refresh, write, read onto registered pins
// Optional feature macro: ARBIT_RR_EN (write/read round-robin instead of write priority).
module sdram_arbit #(
    parameter int unsigned GRANT_TIMEOUT = 1023
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    sdram_arbit_if.slave bus
);
    localparam logic [3:0]  CMD_NOP      = 4'b0111;
    localparam logic [15:0] TIMEOUT_LAST = 16'(GRANT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARBIT = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        grant_err_q, grant_err_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [11:0] addr_q, addr_d;
    logic [1:0]  ba_q, ba_d;
    logic [15:0] dq_q, dq_d;
    logic        oe_q, oe_d;
    logic        pick_rd;
    logic        timeout;

`ifdef ARBIT_RR_EN
    // 1 = last write/read grant was READ
    logic last_rw_q, last_rw_d;

    assign pick_rd = bus.rd_req && !last_rw_q;

    always_comb begin
        last_rw_d = last_rw_q;
        if (state_q == S_ARBIT && state_d == S_WRITE) last_rw_d = 1'b0;
        if (state_q == S_ARBIT && state_d == S_READ)  last_rw_d = 1'b1;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) last_rw_q <= 1'b1;
        else          last_rw_q <= last_rw_d;
    end
`else
    assign pick_rd = 1'b0;
`endif

    assign timeout = (cnt_q == TIMEOUT_LAST);

    always_comb begin
        state_d     = state_q;
        grant_err_d = grant_err_q;
        cnt_d       = '0;
        case (state_q)
            S_INIT:  if (bus.init_end) state_d = S_ARBIT;
            S_ARBIT: begin
                if (bus.ref_req)                state_d = S_AREF;
                else if (bus.wr_req && !pick_rd) state_d = S_WRITE;
                else if (bus.rd_req)            state_d = S_READ;
            end
            S_AREF, S_WRITE, S_READ: begin
                cnt_d = cnt_q + 16'd1;
                // Matching end flag wins over a coincident timeout
                if ((state_q == S_AREF  && bus.ref_end) ||
                    (state_q == S_WRITE && bus.wr_end)  ||
                    (state_q == S_READ  && bus.rd_end)) begin
                    state_d = S_ARBIT;
                end else if (timeout) begin
                    state_d     = S_ARBIT;
                    grant_err_d = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = '0;
        ba_d   = '0;
        dq_d   = '0;
        oe_d   = 1'b0;
        case (state_q)
            S_INIT: begin
                cmd_d  = bus.init_cmd;
                addr_d = bus.init_addr;
            end
            S_AREF: begin
                cmd_d  = bus.ref_cmd;
                addr_d = bus.ref_addr;
            end
            S_WRITE: begin
                cmd_d  = bus.wr_cmd;
                addr_d = bus.wr_addr;
                ba_d   = bus.wr_bank;
                dq_d   = bus.wr_data;
                oe_d   = 1'b1;
            end
            S_READ: begin
                cmd_d  = bus.rd_cmd;
                addr_d = bus.rd_addr;
                ba_d   = bus.rd_bank;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            grant_err_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            addr_q      <= '0;
            ba_q        <= '0;
            dq_q        <= '0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_err_q <= grant_err_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            ba_q        <= ba_d;
            dq_q        <= dq_d;
            oe_q        <= oe_d;
        end
    end

    assign bus.ref_en       = (state_q == S_AREF);
    assign bus.wr_en        = (state_q == S_WRITE);
    assign bus.rd_en        = (state_q == S_READ);
    assign bus.sdram_cke    = 1'b1;
    assign bus.sdram_cmd    = cmd_q;
    assign bus.sdram_addr   = addr_q;
    assign bus.sdram_ba     = ba_q;
    assign bus.sdram_dq_out = dq_q;
    assign bus.sdram_dq_oe  = oe_q;
    assign bus.grant_err    = grant_err_q;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - directed self-checking bench for sdram_arbit
module tb_sdram_arbit;
    localparam int unsigned TMO = 8;

    logic sclk;
    logic s_rst_n;
    int   n_cmp;
    int   n_err;

    sdram_arbit_if bus();

    sdram_arbit #(.GRANT_TIMEOUT(TMO)) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .bus     (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic check_grants(input string tag, input logic r, input logic w, input logic d);
        check({tag, ".ref_en"}, {31'd0, bus.ref_en}, {31'd0, r});
        check({tag, ".wr_en"},  {31'd0, bus.wr_en},  {31'd0, w});
        check({tag, ".rd_en"},  {31'd0, bus.rd_en},  {31'd0, d});
    endtask

    logic exp_wr;

    initial begin
        n_cmp = 0;
        n_err = 0;
        s_rst_n = 1'b0;
        bus.init_end = 1'b0; bus.init_cmd = 4'b0111; bus.init_addr = 12'h400;
        bus.ref_req = 1'b0; bus.ref_end = 1'b0; bus.ref_cmd = 4'b0001; bus.ref_addr = 12'h000;
        bus.wr_req = 1'b0; bus.wr_end = 1'b0; bus.wr_cmd = 4'b0100; bus.wr_addr = 12'h123;
        bus.wr_bank = 2'b01; bus.wr_data = 16'hA5A5;
        bus.rd_req = 1'b0; bus.rd_end = 1'b0; bus.rd_cmd = 4'b0101; bus.rd_addr = 12'h0AB;
        bus.rd_bank = 2'b10;

        tick(); tick();
        check("rst.cmd",  {28'd0, bus.sdram_cmd}, 32'h7);
        check("rst.addr", {20'd0, bus.sdram_addr}, 32'h0);
        check("rst.ba",   {30'd0, bus.sdram_ba}, 32'h0);
        check("rst.dq",   {16'd0, bus.sdram_dq_out}, 32'h0);
        check("rst.oe",   {31'd0, bus.sdram_dq_oe}, 32'h0);
        check("rst.cke",  {31'd0, bus.sdram_cke}, 32'h1);
        check("rst.err",  {31'd0, bus.grant_err}, 32'h0);
        check_grants("rst", 1'b0, 1'b0, 1'b0);

        s_rst_n = 1'b1;
        tick(); tick(); tick();
        check("init.addr", {20'd0, bus.sdram_addr}, 32'h400);
        bus.init_cmd = 4'b0001;
        bus.init_end = 1'b1;
        tick();
        check("init.cmd", {28'd0, bus.sdram_cmd}, 32'h1);
        bus.init_cmd = 4'b0111;
        tick();
        check("arbit.cmd",  {28'd0, bus.sdram_cmd}, 32'h7);
        check("arbit.addr", {20'd0, bus.sdram_addr}, 32'h0);
        check_grants("arbit", 1'b0, 1'b0, 1'b0);

        // All three request together: refresh first
        bus.ref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        tick();
        check_grants("prio.ref", 1'b1, 1'b0, 1'b0);
        bus.ref_req = 1'b0;
        tick();
        check("aref.cmd", {28'd0, bus.sdram_cmd}, 32'h1);
        bus.ref_end = 1'b1;
        tick();
        bus.ref_end = 1'b0;
        check_grants("aref.rel", 1'b0, 1'b0, 1'b0);
        tick();
        check_grants("prio.wr", 1'b0, 1'b1, 1'b0);
        tick();
        check("wr.cmd",  {28'd0, bus.sdram_cmd}, 32'h4);
        check("wr.addr", {20'd0, bus.sdram_addr}, 32'h123);
        check("wr.ba",   {30'd0, bus.sdram_ba}, 32'h1);
        check("wr.dq",   {16'd0, bus.sdram_dq_out}, 32'hA5A5);
        check("wr.oe",   {31'd0, bus.sdram_dq_oe}, 32'h1);
        bus.wr_req = 1'b0;
        bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        check_grants("wr.rel", 1'b0, 1'b0, 1'b0);
        tick();
        check("wr.oe_off", {31'd0, bus.sdram_dq_oe}, 32'h0);
        check("wr.dq_off", {16'd0, bus.sdram_dq_out}, 32'h0);
        check_grants("prio.rd", 1'b0, 1'b0, 1'b1);

        // Refresh arrives during READ: no preemption
        bus.ref_req = 1'b1;
        tick();
        check_grants("rd.hold", 1'b0, 1'b0, 1'b1);
        check("rd.cmd",  {28'd0, bus.sdram_cmd}, 32'h5);
        check("rd.addr", {20'd0, bus.sdram_addr}, 32'h0AB);
        check("rd.ba",   {30'd0, bus.sdram_ba}, 32'h2);
        check("rd.oe",   {31'd0, bus.sdram_dq_oe}, 32'h0);
        bus.rd_req = 1'b0;
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        check_grants("rd.rel", 1'b0, 1'b0, 1'b0);
        tick();
        check_grants("rd.then_ref", 1'b1, 1'b0, 1'b0);

        // Non-matching end flag ignored
        bus.ref_req = 1'b0;
        bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        check_grants("aref.ign_wr_end", 1'b1, 1'b0, 1'b0);

        // ref_end with ref_req still high: release, then regrant
        bus.ref_req = 1'b1;
        bus.ref_end = 1'b1;
        tick();
        bus.ref_end = 1'b0;
        check_grants("aref.end_req", 1'b0, 1'b0, 1'b0);
        tick();
        check_grants("aref.regrant", 1'b1, 1'b0, 1'b0);
        bus.ref_req = 1'b0;
        bus.ref_end = 1'b1;
        tick();
        bus.ref_end = 1'b0;

        // Grant timeout on WRITE
        bus.wr_req = 1'b1;
        tick();
        check_grants("tmo.grant", 1'b0, 1'b1, 1'b0);
        bus.wr_req = 1'b0;
        for (int i = 1; i < TMO; i++) tick();
        check_grants("tmo.pre", 1'b0, 1'b1, 1'b0);
        check("tmo.pre_err", {31'd0, bus.grant_err}, 32'h0);
        tick();
        check_grants("tmo.hit", 1'b0, 1'b0, 1'b0);
        check("tmo.err", {31'd0, bus.grant_err}, 32'h1);

        bus.rd_req = 1'b1;
        tick();
        check_grants("tmo.after_rd", 1'b0, 1'b0, 1'b1);
        bus.rd_req = 1'b0;
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        check("tmo.sticky", {31'd0, bus.grant_err}, 32'h1);

        // Both write and read pending: last grant was READ
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef ARBIT_RR_EN
            exp_wr = (i % 2 == 0);
`else
            exp_wr = 1'b1;
`endif
            tick();
            check_grants($sformatf("rr%0d", i), 1'b0, exp_wr, !exp_wr);
            tick(); tick(); tick();
            if (exp_wr) bus.wr_end = 1'b1;
            else        bus.rd_end = 1'b1;
            tick();
            bus.wr_end = 1'b0;
            bus.rd_end = 1'b0;
            check_grants($sformatf("rr%0d.rel", i), 1'b0, 1'b0, 1'b0);
        end
        tick();
        check("rr.err_kept", {31'd0, bus.grant_err}, 32'h1);

        // Mid-operation reset, init_end low afterwards
        #2;
        s_rst_n = 1'b0;
        #1;
        check("mrst.cmd", {28'd0, bus.sdram_cmd}, 32'h7);
        check("mrst.oe",  {31'd0, bus.sdram_dq_oe}, 32'h0);
        check("mrst.err", {31'd0, bus.grant_err}, 32'h0);
        check_grants("mrst", 1'b0, 1'b0, 1'b0);
        bus.init_end = 1'b0;
        tick();
        s_rst_n = 1'b1;
        tick(); tick(); tick();
        check_grants("mrst.init_wait", 1'b0, 1'b0, 1'b0);
        bus.init_end = 1'b1;
        tick();
        tick();
        check("mrst.regrant_wr", {31'd0, bus.wr_en}, 32'h1);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Command arbiter for the SDRAM controller. It sits between the init, auto-refresh, write and read sequencers and the SDRAM pins. After power-up initialization it grants the shared command/address bus to one sequencer at a time, with refresh at the highest priority, and registers that sequencer's command, address, bank and write data onto the pins. It also flags a sequencer that holds its grant too long.

## Interface
Parameters:
- GRANT_TIMEOUT, 1023: maximum cycles a grant may stay in AREF/WRITE/READ without the matching end flag; range 1..65535.

Ports:
- sclk  in  1  system clock
- s_rst_n  in  1  reset, asynchronous, active-low
- init_end  in  1  init sequencer done; level, held high after completion
- init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init sequencer
- init_addr  in  12  address from init sequencer
- ref_req  in  1  refresh request (level)
- ref_end  in  1  refresh sequence done (1-cycle pulse)
- ref_cmd  in  4  refresh command
- ref_addr  in  12  refresh address
- ref_en  out  1  refresh grant
- wr_req  in  1  write request (level)
- wr_end  in  1  write sequence done (pulse)
- wr_cmd  in  4  write command
- wr_addr  in  12  write address
- wr_bank  in  2  write bank
- wr_data  in  16  write data
- wr_en  out  1  write grant
- rd_req  in  1  read request (level)
- rd_end  in  1  read sequence done (pulse)
- rd_cmd  in  4  read command
- rd_addr  in  12  read address
- rd_bank  in  2  read bank
- rd_en  out  1  read grant
- sdram_cke  out  1  clock enable; constant 1
- sdram_cmd  out  4  registered {cs_n,ras_n,cas_n,we_n}
- sdram_addr  out  12  registered address
- sdram_ba  out  2  registered bank
- sdram_dq_out  out  16  registered write data
- sdram_dq_oe  out  1  registered DQ output enable
- grant_err  out  1  sticky grant-timeout flag

## Operation
- Command encodings: NOP 4'b0111, AREF 4'b0001, PRE 4'b0010, ACT 4'b0011, RD 4'b0101, WR 4'b0100.
- States:
  - INIT: the init_* signals drive the pins. When init_end=1, go to ARBIT.
  - ARBIT: evaluate requests once per cycle. If ref_req, go to AREF; else if wr_req, go to WRITE; else if rd_req, go to READ; else stay in ARBIT.
  - AREF: leave for ARBIT on ref_end.
  - WRITE: leave for ARBIT on wr_end.
  - READ: leave for ARBIT on rd_end.
- Grants are decoded from the state register:
  - ref_en = (state==AREF), wr_en = (state==WRITE), rd_en = (state==READ).
  - At most one grant is high at any time.
- Pin mux by state:
  - INIT: init_cmd/init_addr, ba=0.
  - AREF: ref_cmd/ref_addr, ba=0.
  - WRITE: wr_cmd/wr_addr/wr_bank.
  - READ: rd_cmd/rd_addr/rd_bank.
  - ARBIT: NOP, addr=0, ba=0.
- All pin outputs are registered through one flop stage.
- sdram_dq_oe=1 and sdram_dq_out=wr_data only while state==WRITE; otherwise oe=0 and dq_out=0.
- Requests are ignored in every state other than ARBIT. There is no preemption: a pending ref_req waits until the current end flag.
- An end flag that arrives in a non-matching state is ignored.
- If ref_end and ref_req are both high in AREF, go to ARBIT; the still-high ref_req is granted again from ARBIT.
- Grant timeout:
  - A 16-bit counter clears on entry to AREF/WRITE/READ and increments each cycle in those states.
  - When it reaches GRANT_TIMEOUT, set grant_err and force the state to ARBIT.
  - grant_err clears only on reset.

## Timing
- Reset values:
  - state INIT, all grants 0, grant_err 0.
  - sdram_cmd 4'b0111, sdram_addr 0, sdram_ba 0.
  - sdram_dq_out 0, sdram_dq_oe 0, sdram_cke 1.
- Reset asserted mid-operation returns everything to these values immediately and re-enters INIT; init_end must be seen again.
- Request to grant:
  - A request seen in ARBIT at edge N puts the state in X after edge N, so the grant is high in cycle N+1.
  - The minimum ARBIT dwell between grants is 1 cycle.
- End to release: an end pulse at edge N drops the grant in cycle N+1.
- Sequencer command to pin: a command driven in cycle N appears on sdram_cmd in cycle N+1, a fixed 1-cycle latency for every source.
- Timeout: the error is raised GRANT_TIMEOUT cycles after grant entry; grant_err and the return to ARBIT happen on the same edge.

## Configuration
- ARBIT_RR_EN defined:
  - A 1-bit last_rw register records the most recent WRITE or READ grant (reset to READ).
  - In ARBIT with wr_req and rd_req both high, grant the one not served last.
  - ref_req still has top priority.
- Undefined: write has strict priority over read, and no last_rw register is built.

## Test plan
- Reset, then init_cmd=4'b0001, init_end=1 at cycle 5 → sdram_cmd=4'b0001 one cycle later; state reaches ARBIT; sdram_cmd=4'b0111 thereafter.
- In ARBIT, ref_req=wr_req=rd_req=1 at the same edge → ref_en high next cycle, wr_en=rd_en=0. Pulse ref_end → next grant is wr_en.
- WRITE grant with wr_cmd=4'b0100, wr_bank=2'b01, wr_data=16'hA5A5 → pins carry exactly those values 1 cycle later with sdram_dq_oe=1. wr_end pulse → wr_en=0 and oe=0 on the next cycle.
- During READ, assert ref_req → rd_en stays high until rd_end, then ref_en rises 2 cycles after rd_end (1 cycle ARBIT dwell).
- With GRANT_TIMEOUT=8, grant WRITE and never pulse wr_end → grant_err=1 and wr_en=0 after 8 cycles. grant_err stays 1 until s_rst_n=0.
- With ARBIT_RR_EN, hold wr_req=rd_req=1 and pulse each end flag after 4 cycles → grants alternate WRITE, READ, WRITE, READ. Without the macro → WRITE every time.
